// File: rtl/seq_divider_pkg.sv
// Shared types for the sequential divider: FSM encoding and counter sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Iteration counter only needs to reach bw-1.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none.
module div_step #(
    parameter int bw = 64
) (
    input  logic [bw-1:0] pr_i,
    input  logic          msb_i,
    input  logic [bw-1:0] dv_i,
    output logic [bw-1:0] pr_o,
    output logic          q_o
);

    logic [bw:0] shifted;
    logic [bw:0] diff;

    // The partial remainder is always below the divisor, so both the kept
    // difference and the restored value fit in bw bits.
    always_comb begin
        shifted = {pr_i, msb_i};
        diff    = shifted - {1'b0, dv_i};
        q_o     = ~diff[bw];
        pr_o    = q_o ? diff[bw-1:0] : shifted[bw-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring unsigned divider with start/busy/done handshake.
// Latency: bw cycles from accepted start to done (1 cycle when B==0).
// Backpressure: start is ignored while busy; accepted again in the done cycle.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int bw = 64
) (
    input  logic          CLK,
    input  logic          RESETn,
    input  logic          start,
    input  logic [bw-1:0] A,
    input  logic [bw-1:0] B,
    output logic          busy,
    output logic          done,
    output logic [bw-1:0] quot,
    output logic [bw-1:0] rem,
    output logic          div_by_zero
);

    localparam int CW = cnt_width(bw);
    localparam logic [CW-1:0] LAST_CNT = CW'(bw - 1);

    state_e        state_q, state_d;
    logic [bw-1:0] dq_q, dq_d;
    logic [bw-1:0] dv_q, dv_d;
    logic [bw-1:0] pr_q, pr_d;
    logic [bw-1:0] quot_q, quot_d;
    logic [bw-1:0] rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dbz_q, dbz_d;

    logic [bw-1:0] step_pr;
    logic          step_q;

    div_step #(.bw(bw)) u_step (
        .pr_i  (pr_q),
        .msb_i (dq_q[bw-1]),
        .dv_i  (dv_q),
        .pr_o  (step_pr),
        .q_o   (step_q)
    );

    always_comb begin
        state_d = state_q;
        dq_d    = dq_q;
        dv_d    = dv_q;
        pr_d    = pr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_RUN: begin
                // Quotient bits enter at the LSB as dividend bits leave the MSB.
                dq_d  = {dq_q[bw-2:0], step_q};
                pr_d  = step_pr;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                    quot_d  = dq_d;
                    rem_d   = step_pr;
                end
            end
            default: begin
                if (start) begin
                    dq_d  = A;
                    dv_d  = B;
                    pr_d  = '0;
                    cnt_d = '0;
                    dbz_d = 1'b0;
                    if (B == '0) begin
                        state_d = S_DONE;
                        quot_d  = '1;
                        rem_d   = A;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= S_IDLE;
            dq_q    <= '0;
            dv_q    <= '0;
            pr_q    <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dq_q    <= dq_d;
            dv_q    <= dv_d;
            pr_q    <= pr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign quot        = quot_q;
    assign rem         = rem_q;
    assign div_by_zero = dbz_q;

endmodule
